// File: rtl/paillier_pkg.sv
// Shared types and sizing helpers for the paillier datapath blocks.
package paillier_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  localparam int K_DEF = 128;
  localparam int N_DEF = 32;

  // FIFO occupancy width able to represent a depth of 2N.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/paillier_result_collector_if.sv
// Result word stream from the collector toward the AXI write engine.
interface paillier_result_collector_if #(
  parameter int K  = 128,
  parameter int IW = 5
);
  logic [K-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [IW-1:0] m_block;

  modport master (output m_data, m_valid, m_last, m_block, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_block, output m_ready);
endinterface

// File: rtl/rr_ptr_next.sv
// Round-robin pointer successor: increments and wraps COUNT-1 back to 0.
module rr_ptr_next #(
  parameter int COUNT = 29,
  parameter int W     = 5
) (
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] nxt_o
);

  assign nxt_o = (cur_i == W'(COUNT - 1)) ? '0 : cur_i + W'(1);

endmodule

// File: rtl/paillier_result_collector.sv
// Round-robin drain of per-block result FIFOs into one tagged word stream,
// forwarding whole N-word results and pulsing done after the programmed count.
module paillier_result_collector
  import paillier_pkg::*;
#(
  parameter int BLOCK_COUNT = 29,
  parameter int K           = K_DEF,
  parameter int N           = N_DEF,
  parameter int CW          = cnt_width(N),
  parameter int IW          = $clog2(BLOCK_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              total_results,
  input  logic [BLOCK_COUNT*CW-1:0] fifo_cnt,
  input  logic [BLOCK_COUNT*K-1:0]  fifo_dout,
  output logic [BLOCK_COUNT-1:0]    fifo_rd,
  paillier_result_collector_if.master m,
  output logic                     busy,
  output logic                     done
);

  localparam int WCW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  sel_q, sel_d;
  logic [IW-1:0]  ptr_inc, sel_inc;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [63:0]    res_cnt_q, res_cnt_d;
  logic [63:0]    target_q, target_d;
  logic [CW-1:0]  scan_cnt;
  logic           draining;
  logic           xfer;
  logic           last_word;

  rr_ptr_next #(.COUNT(BLOCK_COUNT), .W(IW)) u_ptr_next (
    .cur_i (ptr_q),
    .nxt_o (ptr_inc)
  );

  rr_ptr_next #(.COUNT(BLOCK_COUNT), .W(IW)) u_sel_next (
    .cur_i (sel_q),
    .nxt_o (sel_inc)
  );

  assign scan_cnt  = fifo_cnt[ptr_q*CW +: CW];
  assign draining  = (state_q == DRAIN);
  assign last_word = (word_cnt_q == WCW'(N - 1));

  // Valid is masked during reset so nothing is popped in the reset cycle.
  assign m.m_valid = draining && !rst;
  assign m.m_data  = draining ? fifo_dout[sel_q*K +: K] : '0;
  assign m.m_block = draining ? sel_q : '0;
  assign m.m_last  = draining && last_word;
  assign xfer      = m.m_valid && m.m_ready;
  assign fifo_rd   = xfer ? (BLOCK_COUNT'(1) << sel_q) : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    word_cnt_d = word_cnt_q;
    res_cnt_d  = res_cnt_q;
    target_d   = target_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d  = total_results;
          res_cnt_d = '0;
          state_d   = (total_results == 64'd0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        // fifo_cnt is only trusted here; during DRAIN N words are guaranteed.
        if (scan_cnt >= CW'(N)) begin
          sel_d      = ptr_q;
          word_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          ptr_d = ptr_inc;
        end
      end
      DRAIN: begin
        if (xfer) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          if (last_word) begin
            res_cnt_d = res_cnt_q + 64'd1;
            ptr_d     = sel_inc;
            state_d   = (res_cnt_q + 64'd1 == target_q) ? DONE : SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      word_cnt_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sel_q    <= sel_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_paillier_result_collector.sv
// Directed bench for paillier_result_collector with a small FIFO model per block.
module tb_paillier_result_collector;

  localparam int BC = 4;
  localparam int K  = 128;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [63:0]       total_results;
  logic [BC*CW-1:0]  fifo_cnt;
  logic [BC*K-1:0]   fifo_dout;
  logic [BC-1:0]     fifo_rd;
  logic              busy;
  logic              done;

  paillier_result_collector_if #(.K(K), .IW(IW)) mif ();

  paillier_result_collector #(.BLOCK_COUNT(BC), .K(K), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .total_results (total_results),
    .fifo_cnt      (fifo_cnt),
    .fifo_dout     (fifo_dout),
    .fifo_rd       (fifo_rd),
    .m             (mif),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [K-1:0] q [BC][$];
  int  pop_cnt [BC];
  int  underflow;
  bit  refill_en;
  int  refill_idx;
  int  exp_order [$];

  initial begin
    foreach (pop_cnt[i]) pop_cnt[i] = 0;
    underflow  = 0;
    refill_idx = 0;
  end

  function automatic logic [K-1:0] val(input int b, input int j);
    return {56'hC0FFEE_0000_0000, 8'(b), 64'(32'hA0 + j)};
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < BC; b++) begin
      if (fifo_rd[b]) begin
        pop_cnt[b]++;
        if (q[b].size() > 0) void'(q[b].pop_front());
        else underflow++;
      end
    end
    if (refill_en && q[1].size() < 2*N) begin
      q[1].push_back(val(1, refill_idx));
      refill_idx++;
    end
    for (int b = 0; b < BC; b++) begin
      fifo_cnt[b*CW +: CW] <= CW'(q[b].size());
      fifo_dout[b*K +: K]  <= (q[b].size() > 0) ? q[b][0] : '0;
    end
  end

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int b, input int n);
    for (int j = 0; j < n; j++) q[b].push_back(val(b, j));
  endtask

  function automatic int pops_total();
    int s = 0;
    for (int b = 0; b < BC; b++) s += pop_cnt[b];
    return s;
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1;
    start = 1'b0;
    refill_en = 1'b0;
    for (int b = 0; b < BC; b++) q[b].delete();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_valid"}, K'(mif.m_valid), '0);
    check({tag, "_last"},  K'(mif.m_last),  '0);
    check({tag, "_data"},  mif.m_data,      '0);
    check({tag, "_block"}, K'(mif.m_block), '0);
    check({tag, "_rd"},    K'(fifo_rd),     '0);
    check({tag, "_busy"},  K'(busy),        '0);
    check({tag, "_done"},  K'(done),        '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Starts a job and follows it to done, checking every accepted beat against
  // exp_order and the known FIFO contents.
  task automatic run_job(input string tag, input logic [63:0] total, input bit rnd);
    int  beats, viol, done_cyc, last_cyc, pops0, eb;
    bit  seen_done, prev_stall;
    logic [K-1:0]  prev_data;
    logic [IW-1:0] prev_blk;
    int  nidx [BC];
    foreach (nidx[i]) nidx[i] = 0;
    beats = 0; viol = 0; done_cyc = -1; last_cyc = -1;
    seen_done = 0; prev_stall = 0; prev_data = '0; prev_blk = '0;
    pops0 = pops_total();
    start = 1'b1;
    total_results = total;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      mif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && (mif.m_data !== prev_data || mif.m_block !== prev_blk)) viol++;
      if (mif.m_valid && mif.m_ready) begin
        if (fifo_rd !== (BC'(1) << mif.m_block)) viol++;
        if (beats / N >= exp_order.size()) viol++;
        else begin
          eb = exp_order[beats / N];
          check({tag, "_blk"},  K'(mif.m_block), K'(eb));
          check({tag, "_dat"},  mif.m_data, val(eb, nidx[eb]));
          check({tag, "_last"}, K'(mif.m_last), K'((beats % N) == N - 1));
          nidx[eb]++;
        end
        beats++;
        last_cyc = cyc;
      end else if (fifo_rd !== '0) viol++;
      prev_stall = mif.m_valid && !mif.m_ready;
      prev_data  = mif.m_data;
      prev_blk   = mif.m_block;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
      @(posedge clk);
      #1;
    end
    mif.m_ready = 1'b1;
    check({tag, "_done_seen"}, K'(seen_done), K'(1));
    check({tag, "_beats"}, K'(beats), K'(exp_order.size() * N));
    check({tag, "_viol"}, K'(viol), '0);
    check({tag, "_pops"}, K'(pops_total() - pops0), K'(beats));
    check({tag, "_done_time"}, K'(done_cyc), K'(last_cyc + 1));
    check({tag, "_busy_after"}, K'(busy), '0);
    check({tag, "_done_once"}, K'(done), '0);
  endtask

  initial begin
    int p2;
    bit got;
    rst = 1'b1;
    start = 1'b0;
    total_results = '0;
    refill_en = 1'b0;
    mif.m_ready = 1'b1;

    do_reset("rst0");
    exp_order = {};
    run_job("zero", 64'd0, 1'b0);
    check("zero_underflow", K'(underflow), '0);

    do_reset("rst1");
    preload(2, N);
    exp_order = {2};
    run_job("single", 64'd1, 1'b0);

    do_reset("rst2");
    preload(0, N); preload(1, N); preload(2, N - 1); preload(3, N);
    p2 = pop_cnt[2];
    exp_order = {0, 1, 3};
    run_job("three", 64'd3, 1'b0);
    check("three_blk2_untouched", K'(pop_cnt[2] - p2), '0);

    do_reset("rst3");
    preload(0, N); preload(1, N); preload(2, N - 1); preload(3, N);
    p2 = pop_cnt[2];
    run_job("stall", 64'd3, 1'b1);
    check("stall_blk2_untouched", K'(pop_cnt[2] - p2), '0);

    do_reset("rst4");
    preload(0, N); preload(3, N);
    refill_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    exp_order = {0, 1, 3, 1};
    run_job("fair", 64'd4, 1'b0);
    refill_en = 1'b0;

    do_reset("rst5");
    preload(2, N);
    p2 = pop_cnt[2];
    start = 1'b1;
    total_results = 64'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mif.m_valid) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("abort_valid_seen", K'(got), K'(1));
    @(posedge clk);
    #1;
    check("abort_beat2", mif.m_data, val(2, 1));
    rst = 1'b1;
    #1;
    check("abort_no_pop", K'(fifo_rd), '0);
    @(posedge clk);
    #1;
    check("abort_valid", K'(mif.m_valid), '0);
    check("abort_data",  mif.m_data, '0);
    check("abort_busy",  K'(busy), '0);
    check("abort_pops",  K'(pop_cnt[2] - p2), K'(1));
    do_reset("rst6");
    preload(2, N);
    exp_order = {2};
    run_job("restart", 64'd1, 1'b0);
    check("final_underflow", K'(underflow), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
